operand_stack: RTL and testbench

Hardware operand stack for the 16-bit stack processor, directly upstream of the combinational `shifter`, the ALU and the other datapath units. It holds the evaluation stack and presents the top two entries as registered outputs. `nos` drives the shifter's `in` and `tos[3:0]` drives `shamt`. Each cycle it executes one stack operation from the control unit: nop, push, pop, or binop (pop two, push result). It flags overflow and underflow.

---
 rtl/operand_stack_if.sv | 27 ++
 rtl/operand_stack.sv | 113 +++++++++++
 tb/tb_operand_stack.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// Bus between the control unit (master) and the operand stack (slave).
// There is no valid/ready: the master presents one op every cycle, and the stack applies it at the next rising edge.
interface operand_stack_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
);
  logic [1:0]       op;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output op, din, err_clr,
    input  tos, nos, count, empty, full, overflow, underflow
  );

  modport slave (
    input  op, din, err_clr,
    output tos, nos, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// Evaluation stack for the stack processor. The top two entries are held in registers,
// so the shifter and the ALU can read them with no added delay.
module operand_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_stack_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_BINOP = 2'b11
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_evt, unf_evt;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] below_nos;

  assign op = op_e'(bus.op);

  // The entry under nos; it becomes the new nos after a pop or a binop.
  assign below_nos = (count_q >= CW'(3)) ? mem_q[AW'(count_q - CW'(3))] : '0;

  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    count_d = count_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    wr_en   = 1'b0;
    wr_addr = AW'(count_q);
    case (op)
      OP_PUSH: begin
        if (count_q == CW'(DEPTH)) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = AW'(count_q);
          tos_d   = bus.din;
          nos_d   = tos_q;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (count_q == '0) begin
          unf_evt = 1'b1;
        end else begin
          tos_d   = nos_q;
          nos_d   = below_nos;
          count_d = count_q - CW'(1);
        end
      end
      OP_BINOP: begin
        if (count_q < CW'(2)) begin
          unf_evt = 1'b1;
        end else begin
          // The result goes into the slot that nos used to occupy.
          wr_en   = 1'b1;
          wr_addr = AW'(count_q - CW'(2));
          tos_d   = bus.din;
          nos_d   = below_nos;
          count_d = count_q - CW'(1);
        end
      end
      default: ;
    endcase
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = (ovf_q & ~bus.err_clr) | ovf_evt;
    unf_d = (unf_q & ~bus.err_clr) | unf_evt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q   <= '0;
      nos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = (count_q == CW'(DEPTH));
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: a driver queues the expected state after each op,
// and a monitor compares the DUT outputs against that queue just after each rising edge.
module tb_operand_stack;
  localparam int WIDTH = 16;
  localparam int CW    = 5;
  localparam int W     = 2 * WIDTH + CW + 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  operand_stack_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  operand_stack #(.DEPTH(16), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int unsigned et, input int unsigned en,
                             input int unsigned ec, input int unsigned eo, input int unsigned eu);
    check({tag, ".tos"},       bus.tos,       et);
    check({tag, ".nos"},       bus.nos,       en);
    check({tag, ".count"},     bus.count,     ec);
    check({tag, ".empty"},     bus.empty,     (ec == 0) ? 1 : 0);
    check({tag, ".full"},      bus.full,      (ec == 16) ? 1 : 0);
    check({tag, ".overflow"},  bus.overflow,  eo);
    check({tag, ".underflow"}, bus.underflow, eu);
  endtask

  // driver
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] din, input logic clr,
                       input logic [WIDTH-1:0] et, input logic [WIDTH-1:0] en,
                       input logic [CW-1:0] ec, input logic eo, input logic eu);
    @(negedge clk);
    bus.op      = op;
    bus.din     = din;
    bus.err_clr = clr;
    exp_q.push_back({et, en, ec, eo, eu});
    @(posedge clk);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_state("op", e[W-1 -: WIDTH], e[W-WIDTH-1 -: WIDTH], e[CW+1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.op      = 2'b00;
    bus.din     = '0;
    bus.err_clr = 1'b0;
    #12;
    check_state("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 16'd0, 1'b0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

    // shifter feed
    do_op(2'b01, 16'd15,  1'b0, 16'd15,  16'd0,  5'd1, 1'b0, 1'b0);
    do_op(2'b01, 16'd3,   1'b0, 16'd3,   16'd15, 5'd2, 1'b0, 1'b0);
    do_op(2'b11, 16'd120, 1'b0, 16'd120, 16'd0,  5'd1, 1'b0, 1'b0);
    do_op(2'b10, 16'd0,   1'b0, 16'd0,   16'd0,  5'd0, 1'b0, 1'b0);

    // fill and drain
    for (int i = 1; i <= 16; i++)
      do_op(2'b01, 16'(i), 1'b0, 16'(i), 16'(i - 1), 5'(i), 1'b0, 1'b0);
    do_op(2'b01, 16'd99, 1'b0, 16'd16, 16'd15, 5'd16, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      do_op(2'b10, 16'd0, 1'b0, 16'(16 - k), (k < 15) ? 16'(15 - k) : 16'd0, 5'(16 - k), 1'b1, 1'b0);
    do_op(2'b00, 16'd0, 1'b1, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

    // underflow
    do_op(2'b10, 16'd0,  1'b0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    do_op(2'b00, 16'd0,  1'b1, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    do_op(2'b01, 16'd7,  1'b0, 16'd7, 16'd0, 5'd1, 1'b0, 1'b0);
    do_op(2'b11, 16'd55, 1'b0, 16'd7, 16'd0, 5'd1, 1'b0, 1'b1);
    do_op(2'b10, 16'd0,  1'b0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    do_op(2'b10, 16'd0,  1'b1, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    do_op(2'b00, 16'd0,  1'b1, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);

    // back-to-back
    do_op(2'b01, 16'd4,  1'b0, 16'd4,  16'd0, 5'd1, 1'b0, 1'b0);
    do_op(2'b01, 16'd5,  1'b0, 16'd5,  16'd4, 5'd2, 1'b0, 1'b0);
    do_op(2'b01, 16'd6,  1'b0, 16'd6,  16'd5, 5'd3, 1'b0, 1'b0);
    do_op(2'b11, 16'd11, 1'b0, 16'd11, 16'd4, 5'd2, 1'b0, 1'b0);
    do_op(2'b11, 16'd15, 1'b0, 16'd15, 16'd0, 5'd1, 1'b0, 1'b0);
    do_op(2'b10, 16'd0,  1'b0, 16'd0,  16'd0, 5'd0, 1'b0, 1'b0);

    // reset asserted mid-cycle with count=3 and underflow set
    do_op(2'b10, 16'd0, 1'b0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b1);
    do_op(2'b01, 16'd1, 1'b0, 16'd1, 16'd0, 5'd1, 1'b0, 1'b1);
    do_op(2'b01, 16'd2, 1'b0, 16'd2, 16'd1, 5'd2, 1'b0, 1'b1);
    do_op(2'b01, 16'd3, 1'b0, 16'd3, 16'd2, 5'd3, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_state("midreset", 0, 0, 0, 0, 0);
    @(negedge clk);
    bus.op = 2'b00;
    rst_n  = 1'b1;
    do_op(2'b00, 16'd0, 1'b0, 16'd0, 16'd0, 5'd0, 1'b0, 1'b0);
    do_op(2'b01, 16'd9, 1'b0, 16'd9, 16'd0, 5'd1, 1'b0, 1'b0);

    @(negedge clk);
    bus.op = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
